// File: rtl/bcd_2of5_serializer.sv
// bcd_2of5_serializer
//
// Purpose: takes a packed word of NDIG BCD digits through a valid/ready load
// port and streams one 2-out-of-5 codeword per accepted beat, most-significant
// digit first. Nibbles 10..15 encode as 00000 and raise err for the frame.
//
// Optional feature (macro B2O5_CHECKSUM_EN): when defined, a mod-10 check
// digit (sum of all valid nibbles, invalid ones counted as 0) is appended as
// one extra beat, and code_last moves to that beat. When undefined, frames
// are exactly NDIG beats and no accumulator exists.
//
// Parameters:
//   NDIG        digits per frame, 1..16 (default 4)
// Ports:
//   clk         clock, all state changes on the rising edge
//   rst         synchronous active-high reset
//   load_valid  load_data is valid
//   load_ready  block can accept a frame (high only in IDLE)
//   load_data   packed BCD, digit NDIG-1 in the top nibble, digit 0 in [3:0]
//   code_valid  code holds a codeword
//   code_ready  sink accepts code this cycle
//   code        current 2-of-5 codeword
//   code_last   current beat is the final beat of the frame
//   err         last loaded frame contained at least one nibble > 9

module bcd_2of5_serializer #(
  parameter int NDIG = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [4*NDIG-1:0]   load_data,
  output logic                code_valid,
  input  logic                code_ready,
  output logic [4:0]          code,
  output logic                code_last,
  output logic                err
);

  // Index needs at least one bit even for a single-digit frame.
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
`ifdef B2O5_CHECKSUM_EN
  localparam logic [1:0] S_CSUM = 2'd2;
`endif

  logic [1:0]        state;
  logic [4*NDIG-1:0] data_q;
  logic [IW-1:0]     idx;
  logic              load_bad;

  function automatic logic [4:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 5'b11000;
      4'd1:    enc = 5'b00011;
      4'd2:    enc = 5'b00101;
      4'd3:    enc = 5'b00110;
      4'd4:    enc = 5'b01001;
      4'd5:    enc = 5'b01010;
      4'd6:    enc = 5'b01100;
      4'd7:    enc = 5'b10001;
      4'd8:    enc = 5'b10010;
      4'd9:    enc = 5'b10100;
      default: enc = 5'b00000;
    endcase
  endfunction

  // Frame-level error flag, evaluated on the incoming word at load time.
  always_comb begin
    load_bad = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (load_data[4*i +: 4] > 4'd9) load_bad = 1'b1;
    end
  end

`ifdef B2O5_CHECKSUM_EN
  logic [7:0] sum;
  logic [3:0] check_digit;
  logic [3:0] csum_q;

  // The check digit is computed from the incoming word so the CSUM beat
  // needs no accumulation over the frame; 8 bits covers 16 * 9 = 144.
  always_comb begin
    sum = 8'd0;
    for (int i = 0; i < NDIG; i++) begin
      if (load_data[4*i +: 4] <= 4'd9) sum = sum + {4'd0, load_data[4*i +: 4]};
    end
    check_digit = 4'(sum % 8'd10);
  end
`endif

  // The captured word is shifted left one digit per accepted beat, so the
  // current digit is always the top nibble; idx only tracks frame position.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      data_q <= '0;
      idx    <= '0;
      err    <= 1'b0;
`ifdef B2O5_CHECKSUM_EN
      csum_q <= 4'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (load_valid) begin
            data_q <= load_data;
            idx    <= '0;
            err    <= load_bad;
`ifdef B2O5_CHECKSUM_EN
            csum_q <= check_digit;
`endif
            state  <= S_SEND;
          end
        end
        S_SEND: begin
          if (code_ready) begin
            data_q <= data_q << 4;
            if (idx == LAST_IDX) begin
              idx <= '0;
`ifdef B2O5_CHECKSUM_EN
              state <= S_CSUM;
`else
              state <= S_IDLE;
`endif
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
`ifdef B2O5_CHECKSUM_EN
        S_CSUM: begin
          if (code_ready) state <= S_IDLE;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs depend on registered state only.
  always_comb begin
    load_ready = (state == S_IDLE);
    code_valid = 1'b0;
    code       = 5'b00000;
    code_last  = 1'b0;
    if (state == S_SEND) begin
      code_valid = 1'b1;
      code       = enc(data_q[4*NDIG-1 -: 4]);
`ifndef B2O5_CHECKSUM_EN
      code_last  = (idx == LAST_IDX);
`endif
    end
`ifdef B2O5_CHECKSUM_EN
    if (state == S_CSUM) begin
      code_valid = 1'b1;
      code       = enc(csum_q);
      code_last  = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_bcd_2of5_serializer.sv
// tb_bcd_2of5_serializer
//
// Purpose: scoreboard bench for bcd_2of5_serializer. Two instances run side
// by side: NDIG=4 for framing, backpressure, reset and random frames, and
// NDIG=1 for the full 16-value nibble sweep. Honours B2O5_CHECKSUM_EN.

module tb_bcd_2of5_serializer;

`ifdef B2O5_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  localparam logic [4:0] ENC [16] = '{
    5'b11000, 5'b00011, 5'b00101, 5'b00110, 5'b01001, 5'b01010, 5'b01100, 5'b10001,
    5'b10010, 5'b10100, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000
  };

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        lv4 = 1'b0, lr4, cv4, cr4 = 1'b1, cl4, e4;
  logic [15:0] ld4 = '0;
  logic [4:0]  c4;
  logic        lv1 = 1'b0, lr1, cv1, cr1 = 1'b1, cl1, e1;
  logic [3:0]  ld1 = '0;
  logic [4:0]  c1;

  int vectors = 0;
  int miscompares = 0;

  logic [5:0] q4[$];
  logic [5:0] q1[$];
  logic       exp_err4 = 1'b0, exp_err1 = 1'b0;
  logic       stall4 = 1'b0, bubble4 = 1'b0, bubble1 = 1'b0;
  logic [5:0] prev4 = '0;
  int         loads4 = 0;

  always #5 clk = ~clk;

  bcd_2of5_serializer #(.NDIG(4)) dut4 (
    .clk(clk), .rst(rst), .load_valid(lv4), .load_ready(lr4), .load_data(ld4),
    .code_valid(cv4), .code_ready(cr4), .code(c4), .code_last(cl4), .err(e4)
  );

  bcd_2of5_serializer #(.NDIG(1)) dut1 (
    .clk(clk), .rst(rst), .load_valid(lv1), .load_ready(lr1), .load_data(ld1),
    .code_valid(cv1), .code_ready(cr1), .code(c1), .code_last(cl1), .err(e1)
  );

  // Reference model: beat k of a frame as {codeword, last}.
  function automatic logic [5:0] expBeat(input logic [63:0] d, input int ndig, input int k);
    int nib;
    int sum;
    sum = 0;
    if (k < ndig) begin
      nib = int'((d >> (4 * (ndig - 1 - k))) & 64'hF);
      return {ENC[nib], (k == ndig - 1) && !CSUM_ON};
    end
    for (int i = 0; i < ndig; i++) begin
      nib = int'((d >> (4 * i)) & 64'hF);
      if (nib <= 9) sum += nib;
    end
    return {ENC[sum % 10], 1'b1};
  endfunction

  function automatic logic expErr(input logic [63:0] d, input int ndig);
    for (int i = 0; i < ndig; i++) begin
      if (((d >> (4 * i)) & 64'hF) > 64'd9) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard for the NDIG=4 instance.
  always @(negedge clk) begin
    if (rst) begin
      q4.delete();
      exp_err4 = 1'b0;
      stall4   = 1'b0;
      bubble4  = 1'b0;
    end else begin
      checkOutput("err4", 32'(e4), 32'(exp_err4));
      checkOutput("ready_vs_valid4", 32'(lr4), 32'(!cv4));
      if (!cv4) checkOutput("idle_code4", {26'd0, c4, cl4}, 32'd0);
      if (bubble4) begin
        checkOutput("bubble4", 32'(lr4), 32'd1);
        bubble4 = 1'b0;
      end
      if (stall4) begin
        checkOutput("hold_valid4", 32'(cv4), 32'd1);
        checkOutput("hold_code4", {26'd0, c4, cl4}, {26'd0, prev4});
      end
      if (cv4 && cr4) begin
        if (q4.size() == 0) begin
          checkOutput("unexpected_beat4", 32'd1, 32'd0);
        end else begin
          logic [5:0] e;
          e = q4.pop_front();
          checkOutput("beat4", {26'd0, c4, cl4}, {26'd0, e});
          if (e[0]) bubble4 = 1'b1;
        end
      end
      stall4 = cv4 && !cr4;
      prev4  = {c4, cl4};
      if (lv4 && lr4) begin
        for (int k = 0; k < 4 + int'(CSUM_ON); k++) q4.push_back(expBeat(64'(ld4), 4, k));
        exp_err4 = expErr(64'(ld4), 4);
        loads4++;
      end
    end
  end

  // Monitor / scoreboard for the NDIG=1 instance.
  always @(negedge clk) begin
    if (rst) begin
      q1.delete();
      exp_err1 = 1'b0;
      bubble1  = 1'b0;
    end else begin
      checkOutput("err1", 32'(e1), 32'(exp_err1));
      if (bubble1) begin
        checkOutput("bubble1", 32'(lr1), 32'd1);
        bubble1 = 1'b0;
      end
      if (cv1 && cr1) begin
        if (q1.size() == 0) begin
          checkOutput("unexpected_beat1", 32'd1, 32'd0);
        end else begin
          logic [5:0] e;
          e = q1.pop_front();
          checkOutput("beat1", {26'd0, c1, cl1}, {26'd0, e});
          if (e[0]) bubble1 = 1'b1;
        end
      end
      if (lv1 && lr1) begin
        for (int k = 0; k < 1 + int'(CSUM_ON); k++) q1.push_back(expBeat(64'(ld1), 1, k));
        exp_err1 = expErr(64'(ld1), 1);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the load edge.
  task automatic applyStimulus(input int which, input logic [15:0] d);
    for (int i = 0; i < 200; i++) begin
      if ((which == 4) ? lr4 : lr1) break;
      @(posedge clk); #1;
    end
    if (which == 4) begin lv4 = 1'b1; ld4 = d; end
    else            begin lv1 = 1'b1; ld1 = d[3:0]; end
    @(posedge clk); #1;
    lv4 = 1'b0;
    lv1 = 1'b0;
  endtask

  task automatic waitDrain(input int which, input bit rnd);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (which == 4) done = (q4.size() == 0) && !cv4;
      else            done = (q1.size() == 0) && !cv1;
      @(posedge clk); #1;
      if (rnd) cr4 = ($urandom_range(0, 3) != 0);
    end
    cr4 = 1'b1;
    if (!done) checkOutput("drain_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    logic [15:0] d;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_ready", 32'(lr4), 32'd1);
    checkOutput("rst_valid", 32'(cv4), 32'd0);
    checkOutput("rst_code", {26'd0, c4, cl4}, 32'd0);
    checkOutput("rst_err", 32'(e4), 32'd0);
    @(posedge clk); #1;

    $display("[TB] frame 0x1907, sink always ready");
    applyStimulus(4, 16'h1907);
    checkOutput("first_beat_latency", 32'(cv4), 32'd1);
    waitDrain(4, 1'b0);

    $display("[TB] frame 0x1907, three stall cycles on beat 2");
    applyStimulus(4, 16'h1907);
    @(posedge clk); #1 cr4 = 1'b0;
    repeat (3) @(posedge clk);
    #1 cr4 = 1'b1;
    waitDrain(4, 1'b0);

    $display("[TB] frame 0x12A4 with invalid nibble");
    applyStimulus(4, 16'h12A4);
    waitDrain(4, 1'b0);

    $display("[TB] load_valid held during SEND");
    n = loads4;
    lv4 = 1'b1;
    ld4 = 16'h1907;
    @(posedge clk); #1;
    ld4 = 16'h5555;
    for (int i = 0; i < 100 && loads4 < n + 2; i++) begin
      @(posedge clk); #1;
    end
    lv4 = 1'b0;
    checkOutput("held_load_count", 32'(loads4 - n), 32'd2);
    waitDrain(4, 1'b0);

    $display("[TB] reset during beat 2");
    applyStimulus(4, 16'h12A4);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_valid", 32'(cv4), 32'd0);
    checkOutput("midrst_err", 32'(e4), 32'd0);
    checkOutput("midrst_ready", 32'(lr4), 32'd1);
    @(posedge clk); #1;
    applyStimulus(4, 16'h0000);
    waitDrain(4, 1'b0);

    $display("[TB] random frames with random backpressure");
    for (int f = 0; f < 30; f++) begin
      d = 16'($urandom);
      if (f % 2 == 1) begin
        for (int j = 0; j < 4; j++) d[4*j +: 4] = 4'($urandom_range(0, 9));
      end
      applyStimulus(4, d);
      waitDrain(4, 1'b1);
    end

    $display("[TB] NDIG=1 sweep of all nibble values");
    for (int v = 0; v < 16; v++) begin
      applyStimulus(1, 16'(v));
      waitDrain(1, 1'b0);
    end

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
